// File: rtl/date_to_doy.sv
// Month/day BCD date plus leap flag -> day-of-year as three BCD digits.
// Multi-cycle: decode digits, validate, accumulate month lengths, double-dabble.
module date_to_doy #(
  parameter int CONV_STEPS = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       leap,
  input  logic [3:0] mm_msb,
  input  logic [3:0] mm_lsb,
  input  logic [3:0] dd_msb,
  input  logic [3:0] dd_lsb,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] doy_hun,
  output logic [3:0] doy_ten,
  output logic [3:0] doy_one
);

  localparam int ACC_W = CONV_STEPS;
  localparam int SR_W  = CONV_STEPS + 12;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    CHECK  = 3'd2,
    ACCUM  = 3'd3,
    CONV   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t            state;
  logic              leap_r;
  logic [3:0]        mm_msb_r, mm_lsb_r, dd_msb_r, dd_lsb_r;
  logic [6:0]        month_p0, day_p0;
  logic              digit_bad_p0;
  logic [3:0]        month;
  logic [3:0]        m;
  logic [ACC_W-1:0]  acc;
  logic [SR_W-1:0]   sr;
  logic [3:0]        step;

  function automatic logic [4:0] month_len(input logic [3:0] mon, input logic lp);
    case (mon)
      4'd2:                      month_len = 5'd28 + {4'd0, lp};
      4'd4, 4'd6, 4'd9, 4'd11:   month_len = 5'd30;
      default:                   month_len = 5'd31;
    endcase
  endfunction

  // One double-dabble iteration: add 3 to BCD nibbles >= 5, then shift left.
  function automatic logic [SR_W-1:0] dd_step(input logic [SR_W-1:0] s);
    logic [SR_W-1:0] t;
    t = s;
    for (int i = 0; i < 3; i++) begin
      if (t[CONV_STEPS+4*i +: 4] >= 4'd5)
        t[CONV_STEPS+4*i +: 4] = t[CONV_STEPS+4*i +: 4] + 4'd3;
    end
    dd_step = {t[SR_W-2:0], 1'b0};
  endfunction

  // Combinational views used at the state boundaries.
  logic [6:0]      month_bin, day_bin;
  logic            digits_bad;
  logic            month_ok, day_ok;
  logic [SR_W-1:0] sr_next;

  always_comb begin
    month_bin  = 7'(mm_msb_r) * 7'd10 + 7'(mm_lsb_r);
    day_bin    = 7'(dd_msb_r) * 7'd10 + 7'(dd_lsb_r);
    digits_bad = (mm_msb_r > 4'd9) || (mm_lsb_r > 4'd9) ||
                 (dd_msb_r > 4'd9) || (dd_lsb_r > 4'd9);
    month_ok   = (month_p0 >= 7'd1) && (month_p0 <= 7'd12);
    day_ok     = (day_p0 >= 7'd1) &&
                 (day_p0 <= {2'b00, month_len(month_p0[3:0], leap_r)});
    sr_next    = dd_step(sr);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      doy_hun      <= 4'd0;
      doy_ten      <= 4'd0;
      doy_one      <= 4'd0;
      leap_r       <= 1'b0;
      mm_msb_r     <= 4'd0;
      mm_lsb_r     <= 4'd0;
      dd_msb_r     <= 4'd0;
      dd_lsb_r     <= 4'd0;
      month_p0     <= 7'd0;
      day_p0       <= 7'd0;
      digit_bad_p0 <= 1'b0;
      month        <= 4'd0;
      m            <= 4'd0;
      acc          <= '0;
      sr           <= '0;
      step         <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mm_msb_r <= mm_msb;
            mm_lsb_r <= mm_lsb;
            dd_msb_r <= dd_msb;
            dd_lsb_r <= dd_lsb;
            leap_r   <= leap;
            err      <= 1'b0;
            busy     <= 1'b1;
            state    <= DECODE;
          end
        end
        // ---- stage p0: digits -> binary month/day ----
        DECODE: begin
          month_p0     <= month_bin;
          day_p0       <= day_bin;
          digit_bad_p0 <= digits_bad;
          state        <= CHECK;
        end
        // ---- stage p1: range validation ----
        CHECK: begin
          if (digit_bad_p0 || !month_ok || !day_ok) begin
            err     <= 1'b1;
            doy_hun <= 4'd0;
            doy_ten <= 4'd0;
            doy_one <= 4'd0;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            month <= month_p0[3:0];
            acc   <= ACC_W'(day_p0);
            m     <= 4'd1;
            state <= ACCUM;
          end
        end
        // ---- stage p2: sum lengths of preceding months ----
        ACCUM: begin
          if (m < month) begin
            acc <= acc + ACC_W'(month_len(m, leap_r));
            m   <= m + 4'd1;
          end else begin
            sr    <= {12'd0, acc};
            step  <= 4'd0;
            state <= CONV;
          end
        end
        // ---- stage p3: binary -> BCD ----
        CONV: begin
          sr   <= sr_next;
          step <= step + 4'd1;
          if (step == 4'(CONV_STEPS - 1)) begin
            doy_hun <= sr_next[CONV_STEPS+8 +: 4];
            doy_ten <= sr_next[CONV_STEPS+4 +: 4];
            doy_one <= sr_next[CONV_STEPS   +: 4];
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_date_to_doy.sv
// Directed bench for date_to_doy: latency, results, error cases, busy/reset behaviour.
module tb_date_to_doy;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       leap = 1'b0;
  logic [3:0] mm_msb = 4'd0, mm_lsb = 4'd0, dd_msb = 4'd0, dd_lsb = 4'd0;
  logic       busy, done, err;
  logic [3:0] doy_hun, doy_ten, doy_one;

  int tests = 0;
  int fails = 0;

  date_to_doy #(.CONV_STEPS(9)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .leap   (leap),
    .mm_msb (mm_msb),
    .mm_lsb (mm_lsb),
    .dd_msb (dd_msb),
    .dd_lsb (dd_lsb),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .doy_hun(doy_hun),
    .doy_ten(doy_ten),
    .doy_one(doy_one)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start one operation and check latency, err and the BCD result.
  // disturb: inject a start pulse and input changes while busy.
  // sid: raise start in the DONE cycle (must be ignored).
  task automatic run_case(input string tag,
                          input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d,
                          input logic lp, input int exp_doy,
                          input logic exp_err, input int exp_lat,
                          input bit disturb, input bit sid);
    int  n;
    bit  got;
    @(negedge clock);
    mm_msb = a; mm_lsb = b; dd_msb = c; dd_lsb = d; leap = lp;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    check({tag, "_busy"}, int'(busy), 1);
    n = 0;
    got = 1'b0;
    while (!got && n < 60) begin
      @(posedge clock);
      #1 n++;
      if (done) got = 1'b1;
      else if (disturb) begin
        if (n == 3) begin
          start = 1'b1; mm_msb = 4'd0; mm_lsb = 4'd1;
          dd_msb = 4'd0; dd_lsb = 4'd1; leap = 1'b1;
        end
        if (n == 4) start = 1'b0;
        if (n == 8) dd_lsb = 4'd5;
      end
    end
    check({tag, "_lat"}, got ? n : -1, exp_lat);
    check({tag, "_err"}, int'(err), int'(exp_err));
    check({tag, "_doy"}, int'({doy_hun, doy_ten, doy_one}), exp_doy);
    if (sid) begin
      mm_msb = 4'd0; mm_lsb = 4'd1; dd_msb = 4'd0; dd_lsb = 4'd1;
      start = 1'b1;
    end
    @(posedge clock);
    #1 start = 1'b0;
    check({tag, "_done_off"}, int'(done), 0);
    check({tag, "_idle"}, int'(busy), 0);
    @(posedge clock);
    #1 check({tag, "_stay_idle"}, int'(busy), 0);
    check({tag, "_err_hold"}, int'(err), int'(exp_err));
    check({tag, "_doy_hold"}, int'({doy_hun, doy_ten, doy_one}), exp_doy);
  endtask

  initial begin
    int pulses;
    repeat (3) @(posedge clock);
    #1 check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_doy", int'({doy_hun, doy_ten, doy_one}), 0);
    @(negedge clock) reset = 1'b0;

    run_case("jan01",  4'd0, 4'd1, 4'd0, 4'd1, 1'b0, 'h001, 1'b0, 12, 1'b0, 1'b1);
    run_case("mar01",  4'd0, 4'd3, 4'd0, 4'd1, 1'b0, 'h060, 1'b0, 14, 1'b0, 1'b0);
    run_case("mar01L", 4'd0, 4'd3, 4'd0, 4'd1, 1'b1, 'h061, 1'b0, 14, 1'b0, 1'b0);
    run_case("dec31L", 4'd1, 4'd2, 4'd3, 4'd1, 1'b1, 'h366, 1'b0, 23, 1'b0, 1'b0);
    run_case("dec31",  4'd1, 4'd2, 4'd3, 4'd1, 1'b0, 'h365, 1'b0, 23, 1'b0, 1'b0);
    run_case("apr30",  4'd0, 4'd4, 4'd3, 4'd0, 1'b0, 'h120, 1'b0, 15, 1'b0, 1'b0);
    run_case("feb29L", 4'd0, 4'd2, 4'd2, 4'd9, 1'b1, 'h060, 1'b0, 13, 1'b0, 1'b0);
    run_case("feb29",  4'd0, 4'd2, 4'd2, 4'd9, 1'b0, 'h000, 1'b1, 2,  1'b0, 1'b0);
    run_case("mon13",  4'd1, 4'd3, 4'd0, 4'd1, 1'b0, 'h000, 1'b1, 2,  1'b0, 1'b0);
    run_case("day00",  4'd0, 4'd1, 4'd0, 4'd0, 1'b0, 'h000, 1'b1, 2,  1'b0, 1'b0);
    run_case("ddA",    4'd0, 4'd1, 4'd0, 4'hA, 1'b0, 'h000, 1'b1, 2,  1'b0, 1'b0);
    run_case("apr31",  4'd0, 4'd4, 4'd3, 4'd1, 1'b0, 'h000, 1'b1, 2,  1'b0, 1'b0);
    run_case("mon00",  4'd0, 4'd0, 4'd1, 4'd5, 1'b0, 'h000, 1'b1, 2,  1'b0, 1'b0);
    run_case("aug15",  4'd0, 4'd8, 4'd1, 4'd5, 1'b0, 'h227, 1'b0, 19, 1'b0, 1'b0);
    run_case("dist",   4'd1, 4'd2, 4'd3, 4'd1, 1'b0, 'h365, 1'b0, 23, 1'b1, 1'b0);

    // Reset in the middle of ACCUM for December.
    @(negedge clock);
    mm_msb = 4'd1; mm_lsb = 4'd2; dd_msb = 4'd3; dd_lsb = 4'd1; leap = 1'b0;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (5) @(posedge clock);
    #1 check("mid_busy", int'(busy), 1);
    reset = 1'b1;
    #1 check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_err", int'(err), 0);
    check("mid_rst_doy", int'({doy_hun, doy_ten, doy_one}), 0);
    @(negedge clock) reset = 1'b0;
    pulses = 0;
    repeat (30) begin
      @(posedge clock);
      #1 if (done) pulses++;
    end
    check("mid_no_done", pulses, 0);

    run_case("after",  4'd1, 4'd2, 4'd3, 4'd1, 1'b1, 'h366, 1'b0, 23, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
